// File: rtl/mem_arbiter_pkg.sv
// Shared types for the local-memory data-port arbiter: memory operation
// encoding, arbiter FSM states and the one-bit port identifier.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  // MEM_IDLE is the all-zero "no access" encoding driven when nothing is granted.
  typedef enum logic [3:0] {
    MEM_IDLE    = 4'd0,
    LOAD_BYTE   = 4'd1,
    LOAD_HALF   = 4'd2,
    LOAD_WORD   = 4'd3,
    LOAD_BYTE_U = 4'd4,
    LOAD_HALF_U = 4'd5,
    STORE_BYTE  = 4'd6,
    STORE_HALF  = 4'd7,
    STORE_WORD  = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  // Wide enough to hold MAX_BURST up to 15.
  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/rr_burst_arbiter.sv
// Two-port round-robin arbiter with a burst limit. Remembers the last
// granted port and how many extra consecutive grants it has had; the owner
// yields to a competing requester once it has had MAX_BURST grants in a row.
module rr_burst_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_SAT  = BURST_CNT_W'(MAX_BURST);

  arb_state_t             state_reg, state_next;
  logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

  // State register: owner and burst counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Grant decision; held off while reset is asserted so no access leaks out.
  always_comb begin
    grant = 2'b00;
    if (resetn) begin
      unique case (state_reg)
        IDLE:    grant = req[0] ? 2'b01 : {req[1], 1'b0};
        OWN0: begin
          if (&req) grant = (burst_cnt_reg < BURST_LAST) ? 2'b01 : 2'b10;
          else      grant = req;
        end
        OWN1: begin
          if (&req) grant = (burst_cnt_reg < BURST_LAST) ? 2'b10 : 2'b01;
          else      grant = req;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Next owner follows the grant; the counter grows only while the owner repeats.
  always_comb begin
    state_next     = IDLE;
    burst_cnt_next = '0;
    if (grant[0]) begin
      state_next = OWN0;
      if (state_reg == OWN0) begin
        burst_cnt_next = (burst_cnt_reg == BURST_SAT) ? burst_cnt_reg
                                                      : burst_cnt_reg + 1'b1;
      end
    end else if (grant[1]) begin
      state_next = OWN1;
      if (state_reg == OWN1) begin
        burst_cnt_next = (burst_cnt_reg == BURST_SAT) ? burst_cnt_reg
                                                      : burst_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the local memory's data port between the core (port 0) and the
// DMA/boot loader (port 1). Issues the granted request combinationally and
// routes the one-cycle-late response back to the port that issued it.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 p0_valid,
  output logic                 p0_ready,
  input  mem_op_t              p0_op,
  input  word_t                p0_addr,
  input  word_t                p0_wdata,
  output logic                 p0_rvalid,
  output word_t                p0_rdata,
  output logic                 p0_error,
  input  logic                 p1_valid,
  output logic                 p1_ready,
  input  mem_op_t              p1_op,
  input  word_t                p1_addr,
  input  word_t                p1_wdata,
  output logic                 p1_rvalid,
  output word_t                p1_rdata,
  output logic                 p1_error,
  output mem_op_t              mem_op,
  output word_t                mem_addr,
  output word_t                mem_wdata,
  input  word_t                mem_rdata,
  input  logic                 mem_error,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  logic [1:0] req;
  logic [1:0] grant;

  logic       rsp_valid_reg;
  port_id_t   rsp_tag_reg;
  logic       rsp_error_reg;

  logic [1:0] rvalid_vec;
  logic [1:0] error_vec;
  word_t      rdata_vec [2];

  assign req = {p1_valid, p0_valid};

  rr_burst_arbiter #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .grant  (grant)
  );

  assign p0_ready = grant[0];
  assign p1_ready = grant[1];

  // Issue mux: granted port drives the memory, otherwise an idle cycle.
  always_comb begin
    mem_op    = MEM_IDLE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[0]) begin
      mem_op    = p0_op;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (grant[1]) begin
      mem_op    = p1_op;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Capture who issued this cycle's access and whether memory flagged it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_reg <= 1'b0;
      rsp_tag_reg   <= 1'b0;
      rsp_error_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= |grant;
      rsp_tag_reg   <= grant[1];
      rsp_error_reg <= mem_error & (|grant);
    end
  end

  // Response demux: only the tagged port sees rvalid, data and error.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rvalid_vec[gi] = rsp_valid_reg && (rsp_tag_reg == port_id_t'(gi));
    assign error_vec[gi]  = rvalid_vec[gi] & rsp_error_reg;
    assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
  end

  assign p0_rvalid = rvalid_vec[0];
  assign p1_rvalid = rvalid_vec[1];
  assign p0_error  = error_vec[0];
  assign p1_error  = error_vec[1];
  assign p0_rdata  = rdata_vec[0];
  assign p1_rdata  = rdata_vec[1];

`ifdef MEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant_cnt_reg [2];
  logic [CNT_WIDTH-1:0] conflict_cnt_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    // Per-port accept counter, wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        grant_cnt_reg[gi] <= '0;
      else if (grant[gi]) grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
    end
  end

  // Cycles in which both ports were competing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     conflict_cnt_reg <= '0;
    else if (&req)   conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
  end

  assign grant_cnt0   = grant_cnt_reg[0];
  assign grant_cnt1   = grant_cnt_reg[1];
  assign conflict_cnt = conflict_cnt_reg;
`else
  assign grant_cnt0   = '0;
  assign grant_cnt1   = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a streak-based arbitration model and a reference memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MB        = 4;
  localparam int CW        = 32;
  localparam int MEM_WORDS = 64;

  logic    clk = 1'b0;
  logic    resetn = 1'b0;
  logic    p0_valid = 1'b0, p1_valid = 1'b0;
  logic    p0_ready, p1_ready;
  mem_op_t p0_op = MEM_IDLE, p1_op = MEM_IDLE;
  word_t   p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic    p0_rvalid, p1_rvalid, p0_error, p1_error;
  word_t   p0_rdata, p1_rdata;
  mem_op_t mem_op;
  word_t   mem_addr, mem_wdata;
  word_t   mem_rdata = '0;
  logic    mem_error;
  logic [CW-1:0] grant_cnt0, grant_cnt1, conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_op(p0_op), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_error(p0_error),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_op(p1_op), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_error(p1_error),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
  );

  // ---------------- memory model (BRAM with registered read) ----------------
  word_t mem [MEM_WORDS];

  function automatic logic acc_err(mem_op_t op, word_t addr);
    if (op == MEM_IDLE) return 1'b0;
    if (addr >= word_t'(MEM_WORDS * 4)) return 1'b1;
    if (addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  assign mem_error = acc_err(mem_op, mem_addr);

  always @(posedge clk) begin
    if (mem_op != MEM_IDLE && !mem_error) begin
      if (mem_op == STORE_WORD) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  // ---------------- reference model ----------------
  word_t ref_mem [MEM_WORDS];
  int    last_owner = -1;   // -1: nobody granted last cycle
  int    streak = 0;        // consecutive grants to last_owner
  int    exp_g0 = 0, exp_g1 = 0, exp_conf = 0;
  int    checks = 0, errors = 0;
  int    cyc = 0;

  // Pending response from the access issued this cycle.
  bit    n_v, n_err, n_load;
  int    n_port;
  word_t n_data;
  int    last_grant;

  function automatic int pick(bit v0, bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (last_owner < 0) return 0;
    if (streak < MB) return last_owner;
    return 1 - last_owner;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last_owner = -1;
    streak     = 0;
    exp_g0     = 0;
    exp_g1     = 0;
    exp_conf   = 0;
  endtask

  // Pre-edge: check grant and issue, then advance the model.
  task automatic issue();
    int      g;
    mem_op_t op;
    word_t   a, d;
    #1;
    g = pick(p0_valid, p1_valid);
    last_grant = g;
    chk("p0_ready", 32'(p0_ready), 32'(g == 0));
    chk("p1_ready", 32'(p1_ready), 32'(g == 1));
    op = MEM_IDLE; a = '0; d = '0;
    if (g == 0) begin op = p0_op; a = p0_addr; d = p0_wdata; end
    if (g == 1) begin op = p1_op; a = p1_addr; d = p1_wdata; end
    chk("mem_op", 32'(mem_op), 32'(op));
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    n_v    = (g >= 0);
    n_port = g;
    n_err  = acc_err(op, a);
    n_load = (op == LOAD_WORD);
    n_data = ref_mem[a[7:2]];
    if (op == STORE_WORD && !n_err) ref_mem[a[7:2]] = d;
    if (g == 0) exp_g0++;
    if (g == 1) exp_g1++;
    if (p0_valid && p1_valid) exp_conf++;
    if (g < 0) begin
      last_owner = -1; streak = 0;
    end else if (g == last_owner) begin
      if (streak <= MB) streak++;
    end else begin
      last_owner = g; streak = 1;
    end
  endtask

  // Post-edge: check the response to the access issued in the previous cycle.
  task automatic check_rsp();
    chk("p0_rvalid", 32'(p0_rvalid), 32'(n_v && n_port == 0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(n_v && n_port == 1));
    chk("p0_error", 32'(p0_error), 32'(n_v && n_port == 0 && n_err));
    chk("p1_error", 32'(p1_error), 32'(n_v && n_port == 1 && n_err));
    if (!(n_v && n_port == 0)) chk("p0_rdata_idle", p0_rdata, 32'h0);
    if (!(n_v && n_port == 1)) chk("p1_rdata_idle", p1_rdata, 32'h0);
    if (n_v && n_load && !n_err) begin
      if (n_port == 0) chk("p0_rdata", p0_rdata, n_data);
      else             chk("p1_rdata", p1_rdata, n_data);
    end
`ifdef MEM_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, 32'(exp_g0));
    chk("grant_cnt1", grant_cnt1, 32'(exp_g1));
    chk("conflict_cnt", conflict_cnt, 32'(exp_conf));
`else
    chk("grant_cnt0_off", grant_cnt0, 32'h0);
    chk("grant_cnt1_off", grant_cnt1, 32'h0);
    chk("conflict_cnt_off", conflict_cnt, 32'h0);
`endif
    $display("cyc %0d v=%b%b grant=%0d rsp_port=%0d err=%b", cyc, p1_valid, p0_valid,
             last_grant, n_v ? n_port : -1, n_err);
  endtask

  task automatic cycle();
    issue();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_rsp();
  endtask

  task automatic set_p0(bit v, mem_op_t op, word_t a, word_t d);
    p0_valid = v; p0_op = op; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(bit v, mem_op_t op, word_t a, word_t d);
    p1_valid = v; p1_op = op; p1_addr = a; p1_wdata = d;
  endtask

  function automatic word_t rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return word_t'($urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return word_t'(MEM_WORDS * 4 + $urandom_range(0, 15) * 4);
    return word_t'($urandom_range(0, MEM_WORDS - 1) * 4);
  endfunction

  task automatic do_reset();
    set_p0(0, MEM_IDLE, '0, '0);
    set_p1(0, MEM_IDLE, '0, '0);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  int seq [16];
  int exp_seq [9];

  initial begin
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < MEM_WORDS; i++) begin
      ref_mem[i] = word_t'($urandom);
      mem[i]    <= ref_mem[i];
    end
    ref_mem[4] = 32'hDEADBEEF;
    mem[4]    <= 32'hDEADBEEF;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_p0_ready", 32'(p0_ready), 32'h0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_mem_op", 32'(mem_op), 32'(MEM_IDLE));
    @(negedge clk);
    resetn = 1'b1;

    // Single-port load of the preloaded word
    set_p0(1, LOAD_WORD, 32'h10, '0);
    cycle();
    chk("single_rdata", p0_rdata, 32'hDEADBEEF);
    set_p0(0, MEM_IDLE, '0, '0);
    cycle();

    // Misaligned store from port 1 is flagged and leaves memory alone
    set_p1(1, STORE_WORD, 32'h2, 32'h12345678);
    cycle();
    chk("store_err_flag", 32'(p1_error), 32'h1);
    set_p1(0, MEM_IDLE, '0, '0);
    cycle();
    chk("store_err_mem", mem[0], ref_mem[0]);

    // Burst limit from a fresh reset: both ports continuously valid
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_p0(1, LOAD_WORD, word_t'(i * 4), '0);
      set_p1(1, LOAD_WORD, word_t'((i + 16) * 4), '0);
      cycle();
      seq[i] = last_grant;
    end
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("burst_seq[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));
    end
`ifdef MEM_ARB_STATS_EN
    chk("burst_g0", grant_cnt0, 32'd8);
    chk("burst_g1", grant_cnt1, 32'd8);
    chk("burst_conf", conflict_cnt, 32'd16);
`endif
    set_p0(0, MEM_IDLE, '0, '0);
    set_p1(0, MEM_IDLE, '0, '0);
    cycle();

    // Reset in the cycle after a p0 accept drops the response
    set_p0(1, LOAD_WORD, 32'h10, '0);
    issue();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    set_p0(0, MEM_IDLE, '0, '0);
    model_reset();
    #1;
    chk("midrst_p0_rvalid", 32'(p0_rvalid), 32'h0);
    chk("midrst_p0_rdata", p0_rdata, 32'h0);
    @(negedge clk);
    chk("midrst_p0_rvalid2", 32'(p0_rvalid), 32'h0);
    resetn = 1'b1;
    set_p0(1, LOAD_WORD, 32'h10, '0);
    set_p1(1, LOAD_WORD, 32'h20, '0);
    cycle();
    chk("after_rst_rdata", p0_rdata, 32'hDEADBEEF);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      set_p0($urandom_range(0, 9) < 7, ($urandom_range(0, 1) != 0) ? LOAD_WORD : STORE_WORD,
             rand_addr(), word_t'($urandom));
      set_p1($urandom_range(0, 9) < 6, ($urandom_range(0, 1) != 0) ? LOAD_WORD : STORE_WORD,
             rand_addr(), word_t'($urandom));
      cycle();
    end
    set_p0(0, MEM_IDLE, '0, '0);
    set_p1(0, MEM_IDLE, '0, '0);
    cycle();

    for (int i = 0; i < MEM_WORDS; i++) begin
      chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data port of the BRAM-backed local memory between two requesters: port 0 is the core data path, port 1 is the DMA/boot loader.
- Runs a valid/ready request handshake on each port and round-robin arbitration with a burst limit.
- Tracks the memory's one-cycle read latency and routes each registered response (rdata, error) back to the port that issued it.
- Sits between the execute/memory stage and the local memory's dmem_* port; the instruction port is untouched.

Parameters:
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (1..15).
- CNT_WIDTH, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- p0_valid / p1_valid  in  1  request valid
- p0_ready / p1_ready  out  1  request accepted this cycle
- p0_op / p1_op  in  mem_op_t  load/store operation
- p0_addr / p1_addr  in  word_t  byte address
- p0_wdata / p1_wdata  in  word_t  store data
- p0_rvalid / p1_rvalid  out  1  response valid, one cycle after accept
- p0_rdata / p1_rdata  out  word_t  load data, already extended by memory
- p0_error / p1_error  out  1  misaligned/out-of-range flag for that access
- mem_op  out  mem_op_t  to memory dmem_op
- mem_addr  out  word_t  to memory dmem_addr
- mem_wdata  out  word_t  to memory dmem_wdata
- mem_rdata  in  word_t  from memory dmem_rdata
- mem_error  in  1  from memory dmem_error; combinational, same cycle as issue
- grant_cnt0 / grant_cnt1 / conflict_cnt  out  CNT_WIDTH  statistics counters

Behaviour:
- Reset values (async, resetn low):
  - FSM returns to IDLE and burst_cnt is 0.
  - All pX_ready, pX_rvalid and pX_error are 0; pX_rdata is 0.
  - mem_op is MEM_IDLE.
  - Any in-flight response is dropped.
- FSM states and grant rules:
  - IDLE (no owner): if both ports request, p0 wins; otherwise the single requester wins.
  - OWN0 / OWN1 (last granted port):
    - Only one port valid: that port is granted. The state moves to that owner. burst_cnt is cleared on an owner change and incremented otherwise, saturating at MAX_BURST.
    - Both ports valid: the owner is granted if burst_cnt < MAX_BURST-1; otherwise the other port is granted and burst_cnt is cleared.
    - No port valid: the state goes to IDLE and burst_cnt is cleared.
- Issue path:
  - pX_ready = grant; combinational, at most one per cycle.
  - The granted port's op/addr/wdata drive mem_* in the same cycle.
  - With no grant, mem_op = MEM_IDLE, mem_addr = 0, mem_wdata = 0.
- Memory backpressure: none. The memory accepts every cycle, so full throughput is one access per cycle.
- Response path:
  - The owner tag and mem_error are registered at the accept edge.
  - The next cycle, rvalid pulses on the tagged port only, for loads and stores alike.
  - rdata = mem_rdata; the non-tagged port's rdata is 0.
  - error = the registered mem_error. On error the memory performs no write, and rdata is don't-care but driven.
  - Back-to-back accepts give back-to-back rvalids, possibly alternating between ports.
- Response consumers have no ready signal; they must sink rvalid in the cycle it is asserted.
- MEM_IDLE cycles produce no rvalid.
- Simultaneous accept and response in one cycle is legal: the new request and the prior response are independent.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - grant_cnt0/1 increment on each accept of the respective port.
  - conflict_cnt increments on every cycle in which both ports are valid.
  - Counters wrap modulo 2^CNT_WIDTH and reset to 0.
- When undefined: all three outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- riscv package gains:
  - MEM_IDLE: mem_op_t value for no access (the non-load/store default encoding).
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - port_id_t (1-bit).
- One natural sub-module: rr_burst_arbiter (FSM plus burst counter, outputs grant[1:0]). The datapath mux and response tagging stay in mem_arbiter.

Test Plan:
- Single port, MAX_BURST=4: p0 LOAD_WORD at addr 0x10 with memory word 0xDEADBEEF -> p0_ready same cycle; p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle; p1_rvalid stays 0.
- Tie from IDLE: p0 and p1 both valid at cycle 0 -> p0 granted; p1 granted only once p0 drops, or after 4 grants.
- Burst limit, MAX_BURST=4: p0 and p1 continuously valid -> grant pattern 0,0,0,0,1,1,1,1,0, with rvalid tags following one cycle later.
- Error passthrough: p1 STORE_WORD at addr 0x2 -> p1_error=1 with p1_rvalid the next cycle; the memory word is unchanged.
- Reset mid-operation: assert resetn low one cycle after a p0 accept -> no p0_rvalid; after release, FSM is in IDLE and the first request is served normally.
- With MEM_ARB_STATS_EN, after the burst-limit test (16 cycles) -> grant_cnt0=8, grant_cnt1=8, conflict_cnt=16.
